// File: rtl/gray_sobel_edge.sv
// Streaming 3x3 Sobel edge magnitude on a gray pixel stream, 3-clock latency with sync pass-through.
// Optional build macro SOBEL_BINARY_EN: outputs all-ones/zero against THRESHOLD instead of the magnitude.
module gray_sobel_edge #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned THRESHOLD = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_gray,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [WIDTH-1:0] o_edge
);

  localparam int unsigned MW = WIDTH + 4;
  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [XW-1:0]    X_END = XW'(H_ACTIVE);
  localparam logic [WIDTH-1:0] THR   = WIDTH'(THRESHOLD);
`ifdef SOBEL_BINARY_EN
  localparam bit BINARY = 1'b1;
`else
  localparam bit BINARY = 1'b0;
`endif

  logic [XW-1:0]    r_x;
  logic [1:0]       r_y;
  logic             w_fall, w_vs_rise, w_in_range, w_ok;
  logic [AW-1:0]    w_addr;

  logic [WIDTH-1:0] r_lb0 [H_ACTIVE];
  logic [WIDTH-1:0] r_lb1 [H_ACTIVE];
  logic [WIDTH-1:0] r_lb0_rd, r_lb1_rd;

  logic             r_de1, r_vs1, r_hs1, r_ok1;
  logic [WIDTH-1:0] r_pix1;
  logic             r_de2, r_vs2, r_hs2, r_ok2;
  logic [WIDTH-1:0] r_win [3][3];

  logic signed [MW-1:0] w_gx, w_gy, w_ax, w_ay;
  logic [MW-1:0]        w_mag;
  logic [WIDTH-1:0]     w_mag_sat, w_edge_val;

  function automatic logic signed [MW-1:0] sx(input logic [WIDTH-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  always_comb begin
    w_fall     = r_de1 & ~i_de;
    w_vs_rise  = i_vsync & ~r_vs1;
    w_in_range = (r_x < X_END);
    w_addr     = r_x[AW-1:0];
    // y saturates at 2, so equality is the y>=2 test; also hides stale line-buffer rows
    w_ok       = w_in_range && (r_x >= XW'(2)) && (r_y == 2'd2);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (w_fall)
        r_x <= '0;
      else if (i_de && w_in_range)
        r_x <= r_x + 1'b1;
      if (w_vs_rise)
        r_y <= '0;
      else if (w_fall && (r_y != 2'd2))
        r_y <= r_y + 2'd1;
    end
  end

  // Read-before-write: both buffers return the old contents at the address being written
  always_ff @(posedge clk) begin
    if (i_de && w_in_range) begin
      r_lb0_rd      <= r_lb0[w_addr];
      r_lb1_rd      <= r_lb1[w_addr];
      r_lb0[w_addr] <= i_gray;
      r_lb1[w_addr] <= r_lb0[w_addr];
    end
  end

  always_comb begin
    w_gx = (sx(r_win[0][2]) + (sx(r_win[1][2]) <<< 1) + sx(r_win[2][2]))
         - (sx(r_win[0][0]) + (sx(r_win[1][0]) <<< 1) + sx(r_win[2][0]));
    w_gy = (sx(r_win[2][0]) + (sx(r_win[2][1]) <<< 1) + sx(r_win[2][2]))
         - (sx(r_win[0][0]) + (sx(r_win[0][1]) <<< 1) + sx(r_win[0][2]));
    w_ax = w_gx[MW-1] ? -w_gx : w_gx;
    w_ay = w_gy[MW-1] ? -w_gy : w_gy;
    w_mag = $unsigned(w_ax) + $unsigned(w_ay);
    w_mag_sat = (|w_mag[MW-1:WIDTH]) ? '1 : w_mag[WIDTH-1:0];
    w_edge_val = BINARY ? ((w_mag_sat >= THR) ? '1 : '0) : w_mag_sat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_de1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_hs1   <= 1'b0;
      r_ok1   <= 1'b0;
      r_pix1  <= '0;
      r_de2   <= 1'b0;
      r_vs2   <= 1'b0;
      r_hs2   <= 1'b0;
      r_ok2   <= 1'b0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          r_win[r][c] <= '0;
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_de    <= 1'b0;
      o_edge  <= '0;
    end else begin
      r_de1  <= i_de;
      r_vs1  <= i_vsync;
      r_hs1  <= i_hsync;
      r_ok1  <= i_de && w_ok;
      r_pix1 <= i_gray;

      r_de2  <= r_de1;
      r_vs2  <= r_vs1;
      r_hs2  <= r_hs1;
      r_ok2  <= r_ok1;
      if (r_de1) begin
        for (int unsigned r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1_rd;
        r_win[1][2] <= r_lb0_rd;
        r_win[2][2] <= r_pix1;
      end

      o_vsync <= r_vs2;
      o_hsync <= r_hs2;
      o_de    <= r_de2;
      o_edge  <= (r_de2 && r_ok2) ? w_edge_val : '0;
    end
  end

endmodule
